// File: rtl/qspi_pkg.sv
// Shared Quad-SPI types: lane modes, transmit FSM states and lane-count helper.
package qspi_pkg;

    typedef enum logic [1:0] {
        QSPI_SINGLE = 2'b00,
        QSPI_DUAL   = 2'b01,
        QSPI_QUAD   = 2'b10,
        QSPI_RSVD   = 2'b11
    } qspi_mode_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_SHIFT = 2'b01,
        TX_DONE  = 2'b10
    } tx_state_e;

    // Number of active data lanes; the reserved encoding behaves as single.
    function automatic logic [2:0] lanes_f(input qspi_mode_e mode);
        case (mode)
            QSPI_DUAL: lanes_f = 3'd2;
            QSPI_QUAD: lanes_f = 3'd4;
            default:   lanes_f = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/qspi_tx_shift.sv
// Quad-SPI transmit shifter: serialises one word onto 1/2/4 lanes, one beat per
// shift_en_i strobe, with bit/lane ordering matching qspi_rx_shift.
module qspi_tx_shift
    import qspi_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              lsb_i,
    input  logic [1:0]        mode_i,
    input  logic              shift_en_i,
    input  logic              abort_i,
    output logic [3:0]        qsd_o,
    output logic [3:0]        qsd_oe_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    function automatic logic [CNT_W-1:0] beats_f(input qspi_mode_e mode);
        beats_f = CNT_W'(DATA_W / 32'(lanes_f(mode)));
    endfunction

    tx_state_e          state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               lsb_q, lsb_d;
    qspi_mode_e         mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         qsd_q, qsd_d;
    logic [3:0]         oe_q, oe_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    int unsigned        lanes_n;
    int unsigned        idx_n;
    int unsigned        pos_n;
    logic [3:0]         beat_w;
    logic [3:0]         oe_mask;

    // Next-state logic; cnt_q holds the number of beats still to present.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        lsb_d   = lsb_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            TX_IDLE: begin
                if (valid_i) begin
                    state_d = TX_SHIFT;
                    shift_d = data_i;
                    lsb_d   = lsb_i;
                    mode_d  = qspi_mode_e'(mode_i);
                    cnt_d   = beats_f(qspi_mode_e'(mode_i));
                end
            end
            TX_SHIFT: begin
                if (abort_i) begin
                    state_d = TX_IDLE;
                end else if (shift_en_i) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = TX_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            TX_DONE: begin
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so beat 0 appears right after accept.
    always_comb begin
        lanes_n = 32'(lanes_f(mode_d));
        idx_n   = 32'(beats_f(mode_d) - cnt_d);
        pos_n   = lsb_d ? (lanes_n * idx_n) : (DATA_W - lanes_n * (idx_n + 32'd1));
        beat_w  = 4'(shift_d >> pos_n);
        oe_mask = 4'((5'd1 << lanes_f(mode_d)) - 5'd1);
        qsd_d   = 4'b0000;
        oe_d    = 4'b0000;
        if (state_d == TX_SHIFT) begin
            oe_d  = oe_mask;
            qsd_d = beat_w & oe_mask;
        end
        ready_d = (state_d == TX_IDLE);
        busy_d  = (state_d == TX_SHIFT);
        done_d  = (state_d == TX_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TX_IDLE;
            shift_q <= '0;
            lsb_q   <= 1'b0;
            mode_q  <= QSPI_SINGLE;
            cnt_q   <= '0;
            qsd_q   <= 4'b0000;
            oe_q    <= 4'b0000;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            lsb_q   <= lsb_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            qsd_q   <= qsd_d;
            oe_q    <= oe_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign qsd_o    = qsd_q;
    assign qsd_oe_o = oe_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_qspi_tx_shift.sv
// Self-checking bench for qspi_tx_shift: directed scenarios plus random words
// against a bit-stream reference model and an rx-style loopback reassembly.
module tb_qspi_tx_shift;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic        valid;
    logic        lsb;
    logic [1:0]  mode;
    logic        shift_en;
    logic        abort;
    logic        sel8;

    logic        valid32, valid8;
    logic        ready32, ready8, busy32, busy8, done32, done8;
    logic [3:0]  qsd32, qsd8, oe32, oe8;

    logic        ready_o, busy_o, done_o;
    logic [3:0]  qsd_o, oe_o;

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_oe;

    assign valid32 = valid & ~sel8;
    assign valid8  = valid & sel8;
    assign ready_o = sel8 ? ready8 : ready32;
    assign busy_o  = sel8 ? busy8  : busy32;
    assign done_o  = sel8 ? done8  : done32;
    assign qsd_o   = sel8 ? qsd8   : qsd32;
    assign oe_o    = sel8 ? oe8    : oe32;

    qspi_tx_shift #(.DATA_W(32)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid32),
        .ready_o(ready32), .lsb_i(lsb), .mode_i(mode), .shift_en_i(shift_en),
        .abort_i(abort), .qsd_o(qsd32), .qsd_oe_o(oe32), .busy_o(busy32),
        .done_o(done32)
    );

    qspi_tx_shift #(.DATA_W(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data[7:0]), .valid_i(valid8),
        .ready_o(ready8), .lsb_i(lsb), .mode_i(mode), .shift_en_i(shift_en),
        .abort_i(abort), .qsd_o(qsd8), .qsd_oe_o(oe8), .busy_o(busy8),
        .done_o(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: lay the word out as a serial bit stream, cut it into lane groups.
    task automatic build(input logic [31:0] word, input int w, input logic [1:0] m, input logic l);
        int   nl;
        logic b;
        logic [3:0] v;
        nl = (m == 2'b10) ? 4 : (m == 2'b01) ? 2 : 1;
        exp_oe = (nl == 4) ? 4'hF : (nl == 2) ? 4'h3 : 4'h1;
        exp_q.delete();
        for (int g = 0; g < w / nl; g++) begin
            v = 4'h0;
            for (int j = 0; j < nl; j++) begin
                int s;
                s = g * nl + j;
                b = l ? word[s] : word[w - 1 - s];
                if (l) v[j] = b;
                else   v[nl - 1 - j] = b;
            end
            exp_q.push_back(v);
        end
    endtask

    // cut_at >= 0 interrupts the word at that beat: by abort_i, or by reset if cut_rst.
    task automatic send(input logic [31:0] word, input int w, input logic [1:0] m,
                        input logic l, input int gap, input int cut_at, input logic cut_rst);
        int          n;
        int          nb;
        int          nl;
        logic [31:0] acc;
        logic [31:0] wmask;
        build(word, w, m, l);
        nb    = exp_q.size();
        nl    = 32 / ((w == 32) ? nb : nb * 4);
        nl    = w / nb;
        wmask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        n = 0;
        while (ready_o !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("ready_before_accept", {31'd0, ready_o}, 32'd1);
        data  = word;
        mode  = m;
        lsb   = l;
        valid = 1'b1;
        step();
        valid = 1'b0;
        acc   = 32'd0;
        for (int k = 0; k < nb; k++) begin
            if (l) acc = acc | (32'(qsd_o & exp_oe) << (nl * k));
            else   acc = (acc << nl) | 32'(qsd_o & exp_oe);
            for (int h = 0; h < gap; h++) begin
                chk("beat_qsd", {28'd0, qsd_o}, {28'd0, exp_q[k]});
                chk("beat_oe", {28'd0, oe_o}, {28'd0, exp_oe});
                chk("busy_in_shift", {31'd0, busy_o}, 32'd1);
                chk("ready_in_shift", {31'd0, ready_o}, 32'd0);
                chk("done_in_shift", {31'd0, done_o}, 32'd0);
                data  = $urandom;
                valid = (k < nb - 1);
                if (k == cut_at && h == gap - 1) begin
                    valid = 1'b0;
                    if (cut_rst) begin
                        rst_n = 1'b0;
                        #1;
                        chk("rst_ready", {31'd0, ready_o}, 32'd1);
                        chk("rst_busy", {31'd0, busy_o}, 32'd0);
                        chk("rst_done", {31'd0, done_o}, 32'd0);
                        chk("rst_qsd", {28'd0, qsd_o}, 32'd0);
                        chk("rst_oe", {28'd0, oe_o}, 32'd0);
                        step();
                        step();
                        rst_n = 1'b1;
                    end else begin
                        abort = 1'b1;
                        step();
                        abort = 1'b0;
                        chk("abort_ready", {31'd0, ready_o}, 32'd1);
                        chk("abort_busy", {31'd0, busy_o}, 32'd0);
                        chk("abort_oe", {28'd0, oe_o}, 32'd0);
                        chk("abort_qsd", {28'd0, qsd_o}, 32'd0);
                        chk("abort_done", {31'd0, done_o}, 32'd0);
                        step();
                        chk("abort_no_done", {31'd0, done_o}, 32'd0);
                    end
                    return;
                end
                shift_en = (h == gap - 1);
                step();
                shift_en = 1'b0;
            end
        end
        valid = 1'b0;
        chk("done_pulse", {31'd0, done_o}, 32'd1);
        chk("done_oe", {28'd0, oe_o}, 32'd0);
        chk("done_qsd", {28'd0, qsd_o}, 32'd0);
        chk("done_busy", {31'd0, busy_o}, 32'd0);
        chk("done_ready", {31'd0, ready_o}, 32'd0);
        step();
        chk("after_done_pulse", {31'd0, done_o}, 32'd0);
        chk("after_done_ready", {31'd0, ready_o}, 32'd1);
        chk("loopback_word", acc, word & wmask);
    endtask

    initial begin
        rst_n    = 1'b0;
        data     = 32'd0;
        valid    = 1'b0;
        lsb      = 1'b0;
        mode     = 2'b00;
        shift_en = 1'b0;
        abort    = 1'b0;
        sel8     = 1'b0;
        step();
        chk("reset_ready", {31'd0, ready32}, 32'd1);
        chk("reset_busy", {31'd0, busy32}, 32'd0);
        chk("reset_done", {31'd0, done32}, 32'd0);
        chk("reset_qsd", {28'd0, qsd32}, 32'd0);
        chk("reset_oe", {28'd0, oe32}, 32'd0);
        chk("reset_ready8", {31'd0, ready8}, 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // abort while idle must not disturb anything
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_ready", {31'd0, ready_o}, 32'd1);
        chk("idle_abort_busy", {31'd0, busy_o}, 32'd0);

        send(32'h8765_4321, 32, 2'b10, 1'b0, 1, -1, 1'b0);
        send(32'h8765_4321, 32, 2'b10, 1'b1, 1, -1, 1'b0);
        send(32'h8000_0001, 32, 2'b00, 1'b0, 1, -1, 1'b0);

        sel8 = 1'b1;
        send(32'h0000_00C3, 8, 2'b01, 1'b0, 3, -1, 1'b0);
        send(32'h0000_005A, 8, 2'b01, 1'b1, 2, -1, 1'b0);
        sel8 = 1'b0;

        send(32'hDEAD_BEEF, 32, 2'b10, 1'b0, 1, 3, 1'b0);
        send(32'h1234_5678, 32, 2'b10, 1'b1, 2, -1, 1'b0);

        send(32'h0F0F_F0F0, 32, 2'b01, 1'b0, 1, 5, 1'b1);
        send(32'hA5A5_A5A5, 32, 2'b10, 1'b0, 1, -1, 1'b0);

        send(32'h4000_0002, 32, 2'b11, 1'b1, 1, -1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            send($urandom, 32, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 3), -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
